sw_lap_ctrl: RTL and testbench

Stopwatch front-end sequencer that sits between the board buttons and `sw_ctrl` and the display register of the time counter. It generates the 1 ms `m_sec` timebase. It debounces the start/stop and lap buttons into single-cycle pulses. It runs the lap (split) state machine that decides when the display register captures the live count and when it is frozen.

---
 rtl/sw_lap_ctrl.sv | 158 +++++++++++++++
 tb/tb_sw_lap_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sw_lap_ctrl.sv
// Stopwatch front-end sequencer: 1 ms timebase, button conditioning
// (2-FF sync + tick-based debounce + press pulse) and the lap/split FSM
// that decides when the display register captures the live count.
//
// state | meaning
// LIVE  | display follows the running counter, reloaded on every m_sec
// HOLD  | display frozen on a captured split value, lap LED on
module sw_lap_ctrl #(
  parameter int CLK_DIV = 50000,
  parameter int DB_MS   = 10
) (
  input  logic clk,
  input  logic rst_btn,
  input  logic ss_btn,
  input  logic lap_btn,
  input  logic timer_on,
  input  logic timer_clr,
  output logic m_sec,
  output logic ss_pulse,
  output logic lap_pulse,
  output logic disp_load,
  output logic disp_hold
);

  localparam int PC_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int DC_W = $clog2(DB_MS + 1);
  localparam logic [PC_W-1:0] PC_LAST = PC_W'(CLK_DIV - 1);
  localparam logic [DC_W-1:0] DC_LAST = DC_W'(DB_MS - 1);

  typedef enum logic {
    LIVE = 1'b0,
    HOLD = 1'b1
  } state_t;

  // bit 0 = start/stop, bit 1 = lap
  logic [1:0]      btn_raw;
  logic [1:0]      sync1_q;
  logic [1:0]      sync2_q;
  logic [1:0]      db_q;
  logic [1:0]      db_d;
  logic [1:0]      db_dly_q;
  logic [1:0]      pulse_q;
  logic [DC_W-1:0] dc_q [2];
  logic [DC_W-1:0] dc_d [2];

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;
  logic            m_sec_q;

  state_t          state_q;
  logic            disp_load_q;
  logic            disp_hold_q;

  assign btn_raw = {lap_btn, ss_btn};

  // Prescaler wrap: 0..CLK_DIV-1
  always_comb begin
    pc_d = pc_q + 1'b1;
    if (pc_q == PC_LAST) begin
      pc_d = '0;
    end
  end

  // Free-running prescaler; tick is registered so it lands one cycle after the last count
  always_ff @(posedge clk or negedge rst_btn) begin
    if (!rst_btn) begin
      pc_q    <= '0;
      m_sec_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      m_sec_q <= (pc_q == PC_LAST);
    end
  end

  // Debounce next-state: count ticks of disagreement, flip after DB_MS of them
  always_comb begin
    db_d = db_q;
    dc_d = dc_q;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] == db_q[i]) begin
        dc_d[i] = '0;
      end else if (m_sec_q) begin
        if (dc_q[i] == DC_LAST) begin
          db_d[i] = ~db_q[i];
          dc_d[i] = '0;
        end else begin
          dc_d[i] = dc_q[i] + 1'b1;
        end
      end
    end
  end

  // Synchronizers, debounce state and press-edge pulses for both buttons
  always_ff @(posedge clk or negedge rst_btn) begin
    if (!rst_btn) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      db_q     <= '0;
      db_dly_q <= '0;
      pulse_q  <= '0;
      dc_q[0]  <= '0;
      dc_q[1]  <= '0;
    end else begin
      sync1_q  <= btn_raw;
      sync2_q  <= sync1_q;
      db_q     <= db_d;
      db_dly_q <= db_q;
      pulse_q  <= db_q & ~db_dly_q;
      dc_q[0]  <= dc_d[0];
      dc_q[1]  <= dc_d[1];
    end
  end

  // Lap FSM with registered display controls; clear wins over a coincident lap press
  always_ff @(posedge clk or negedge rst_btn) begin
    if (!rst_btn) begin
      state_q     <= LIVE;
      disp_load_q <= 1'b0;
      disp_hold_q <= 1'b0;
    end else if (timer_clr) begin
      state_q     <= LIVE;
      disp_load_q <= 1'b1;
      disp_hold_q <= 1'b0;
    end else begin
      case (state_q)
        LIVE: begin
          if (pulse_q[1] && timer_on) begin
            state_q     <= HOLD;
            disp_load_q <= 1'b1;
            disp_hold_q <= 1'b1;
          end else begin
            state_q     <= LIVE;
            disp_load_q <= m_sec_q;
            disp_hold_q <= 1'b0;
          end
        end
        HOLD: begin
          if (pulse_q[1]) begin
            state_q     <= LIVE;
            disp_load_q <= 1'b1;
            disp_hold_q <= 1'b0;
          end else begin
            state_q     <= HOLD;
            disp_load_q <= 1'b0;
            disp_hold_q <= 1'b1;
          end
        end
      endcase
    end
  end

  assign m_sec     = m_sec_q;
  assign ss_pulse  = pulse_q[0];
  assign lap_pulse = pulse_q[1];
  assign disp_load = disp_load_q;
  assign disp_hold = disp_hold_q;

endmodule

// File: tb/tb_sw_lap_ctrl.sv
// Bench for sw_lap_ctrl with CLK_DIV=4, DB_MS=2.
module tb_sw_lap_ctrl;

  localparam int EV_SS  = 0;
  localparam int EV_LAP = 1;
  localparam int EV_H1  = 2;
  localparam int EV_H0  = 3;

  logic clk       = 1'b0;
  logic rst_btn   = 1'b0;
  logic ss_btn    = 1'b0;
  logic lap_btn   = 1'b0;
  logic timer_on  = 1'b0;
  logic timer_clr = 1'b0;
  logic m_sec, ss_pulse, lap_pulse, disp_load, disp_hold;

  int tests = 0;
  int fails = 0;
  int exp_q[$];
  int ss_cnt = 0;
  int lap_cnt = 0;
  int ld_cnt = 0;
  logic prev_ss = 1'b0, prev_lap = 1'b0, prev_hold = 1'b0;

  sw_lap_ctrl #(.CLK_DIV(4), .DB_MS(2)) dut (
    .clk       (clk),
    .rst_btn   (rst_btn),
    .ss_btn    (ss_btn),
    .lap_btn   (lap_btn),
    .timer_on  (timer_on),
    .timer_clr (timer_clr),
    .m_sec     (m_sec),
    .ss_pulse  (ss_pulse),
    .lap_pulse (lap_pulse),
    .disp_load (disp_load),
    .disp_hold (disp_hold)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic string ev_name(input int k);
    case (k)
      EV_SS:   return "ss_pulse";
      EV_LAP:  return "lap_pulse";
      EV_H1:   return "hold_rise";
      default: return "hold_fall";
    endcase
  endfunction

  task automatic observe(input int kind);
    int e;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL sb_unexpected: got %s, expected no event (t=%0t)", ev_name(kind), $time);
    end else begin
      e = exp_q.pop_front();
      if (e != kind) begin
        fails++;
        $display("FAIL sb_order: got %s, expected %s (t=%0t)", ev_name(kind), ev_name(e), $time);
      end
    end
  endtask

  // Monitor: turns DUT output activity into events and pops the scoreboard
  always @(negedge clk) begin
    if (!rst_btn) begin
      prev_ss   = 1'b0;
      prev_lap  = 1'b0;
      prev_hold = 1'b0;
    end else begin
      if (ss_pulse) begin
        check("ss_width", prev_ss, 0);
        ss_cnt++;
        observe(EV_SS);
      end
      if (lap_pulse) begin
        check("lap_width", prev_lap, 0);
        lap_cnt++;
        observe(EV_LAP);
      end
      if (disp_hold != prev_hold) begin
        check("hold_edge_load", disp_load, 1);
        observe(disp_hold ? EV_H1 : EV_H0);
      end
      if (disp_load) ld_cnt++;
      prev_ss   = ss_pulse;
      prev_lap  = lap_pulse;
      prev_hold = disp_hold;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Advance to the next cycle in which m_sec is high (bounded)
  task automatic wait_msec();
    bit found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      tick();
      if (m_sec) found = 1'b1;
    end
    check("msec_timeout", int'(found), 1);
  endtask

  // Aligned lap press: pulse appears 10 cycles after the m_sec cycle of the press
  task automatic lap_press_release();
    wait_msec();
    lap_btn = 1'b1;
    ticks(12);
    lap_btn = 1'b0;
    ticks(16);
  endtask

  initial begin
    int base;
    int early;
    bit found;

    // Reset and timebase
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_outputs", {m_sec, ss_pulse, lap_pulse, disp_load, disp_hold}, 0);
    end
    rst_btn = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      check($sformatf("m_sec_edge%0d", k), m_sec, (k % 4 == 0) ? 1 : 0);
    end

    // Glitch: 5 clk high spans only one tick
    base = ss_cnt;
    ss_btn = 1'b1;
    ticks(5);
    ss_btn = 1'b0;
    ticks(16);
    check("glitch_no_ss", ss_cnt - base, 0);

    // Long press: one pulse, release gives none
    wait_msec();
    exp_q.push_back(EV_SS);
    base = ss_cnt;
    ss_btn = 1'b1;
    ticks(20);
    ss_btn = 1'b0;
    ticks(20);
    check("ss_one_pulse", ss_cnt - base, 1);

    // Lap capture while running
    timer_on = 1'b1;
    base = ld_cnt;
    ticks(20);
    check("live_loads", ld_cnt - base, 5);
    exp_q.push_back(EV_LAP);
    exp_q.push_back(EV_H1);
    wait_msec();
    lap_btn = 1'b1;
    ticks(12);
    check("hold_set", disp_hold, 1);
    lap_btn = 1'b0;
    base = ld_cnt;
    ticks(20);
    check("hold_no_loads", ld_cnt - base, 0);
    exp_q.push_back(EV_LAP);
    exp_q.push_back(EV_H0);
    wait_msec();
    lap_btn = 1'b1;
    ticks(12);
    check("hold_clear", disp_hold, 0);
    lap_btn = 1'b0;
    base = ld_cnt;
    ticks(20);
    check("loads_resume", ld_cnt - base, 5);

    // Lap ignored while stopped
    timer_on = 1'b0;
    exp_q.push_back(EV_LAP);
    lap_press_release();
    check("stopped_no_hold", disp_hold, 0);

    // Clear in HOLD coincident with lap pulse
    timer_on = 1'b1;
    exp_q.push_back(EV_LAP);
    exp_q.push_back(EV_H1);
    lap_press_release();
    check("clr_pre_hold", disp_hold, 1);
    exp_q.push_back(EV_LAP);
    exp_q.push_back(EV_H0);
    wait_msec();
    lap_btn = 1'b1;
    ticks(10);
    check("clr_align_lap", lap_pulse, 1);
    timer_clr = 1'b1;
    tick();
    timer_clr = 1'b0;
    check("clr_hold_off", disp_hold, 0);
    check("clr_load", disp_load, 1);
    tick();
    check("clr_single_load", disp_load, 0);
    lap_btn = 1'b0;
    ticks(16);

    // Clear in LIVE coincident with lap pulse: clear must win, no HOLD
    exp_q.push_back(EV_LAP);
    wait_msec();
    lap_btn = 1'b1;
    ticks(10);
    check("clr2_align_lap", lap_pulse, 1);
    timer_clr = 1'b1;
    tick();
    timer_clr = 1'b0;
    check("clr2_load", disp_load, 1);
    check("clr2_live", disp_hold, 0);
    lap_btn = 1'b0;
    ticks(16);
    check("clr2_stay_live", disp_hold, 0);

    // Async reset mid-debounce while in HOLD
    exp_q.push_back(EV_LAP);
    exp_q.push_back(EV_H1);
    lap_press_release();
    check("rst_pre_hold", disp_hold, 1);
    wait_msec();
    lap_btn = 1'b1;
    ticks(5);
    #2;
    rst_btn = 1'b0;
    #1;
    check("async_rst_outputs", {m_sec, ss_pulse, lap_pulse, disp_load, disp_hold}, 0);
    ticks(2);
    check("rst_hold_outputs", {m_sec, ss_pulse, lap_pulse, disp_load, disp_hold}, 0);
    exp_q.push_back(EV_LAP);
    exp_q.push_back(EV_H1);
    rst_btn = 1'b1;
    early = 0;
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (lap_pulse) early++;
    end
    check("rst_full_debounce", early, 0);
    found = 1'b0;
    for (int k = 0; k < 6 && !found; k++) begin
      tick();
      if (lap_pulse) found = 1'b1;
    end
    check("rst_lap_arrives", int'(found), 1);
    ticks(2);
    check("rst_then_hold", disp_hold, 1);
    lap_btn = 1'b0;
    ticks(20);

    check("sb_drain", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
